// File: rtl/obc_pkg.sv
// Shared definitions for the OBC DFT sequencer: FSM encoding, widths and the
// default offset-binary-coding seed.
package obc_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    localparam logic signed [DATA_W-1:0] OFFSET_INIT = 32'shFF00_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/feedback_mux.sv
// Feedback selection for the bit-serial OBC accumulation: seeds bin 0 with the
// offset, restarts other bins from zero, otherwise halves the running sum.
module feedback_mux
    import obc_pkg::*;
#(
    parameter logic signed [31:0] OFFSET_INIT = 32'shFF00_0000
) (
    input  logic        [IDX_W-1:0]  i,
    input  logic        [IDX_W-1:0]  k,
    input  logic signed [DATA_W-1:0] acc,
    output logic signed [DATA_W-1:0] fb
);

    // Bit 0 starts a new bin; later bits weight the previous sum by one half.
    always_comb begin
        if (i == '0) begin
            fb = (k == '0) ? OFFSET_INIT : '0;
        end else begin
            fb = acc >>> 1;
        end
    end

endmodule

// File: rtl/obc_dft_sequencer.sv
// Bit-serial OBC DFT sequencer: walks bit index i and bin index k, accumulates
// LUT partial sums per bin and hands each bin result out with valid/ready.
module obc_dft_sequencer #(
    parameter logic signed [31:0] OFFSET_INIT = obc_pkg::OFFSET_INIT,
    parameter int                 NBITS       = 16,
    parameter int                 NBINS       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic        [obc_pkg::IDX_W-1:0]      bit_idx,
    output logic        [obc_pkg::IDX_W-1:0]      bin_idx,
    input  logic signed [obc_pkg::DATA_W-1:0]     lut_data,
    output logic signed [obc_pkg::DATA_W-1:0]     out_data,
    output logic        [obc_pkg::IDX_W-1:0]      out_bin,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  done
);

    import obc_pkg::*;

    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(NBITS - 1);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NBINS - 1);

    state_t                    state_q, state_d;
    logic        [IDX_W-1:0]   i_q, i_d;
    logic        [IDX_W-1:0]   k_q, k_d;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic        [IDX_W-1:0]   out_bin_q, out_bin_d;
    logic                      out_valid_q, out_valid_d;
    logic                      done_q, done_d;

    logic signed [DATA_W-1:0]  fb;
    logic signed [DATA_W-1:0]  result;

    feedback_mux #(
        .OFFSET_INIT (OFFSET_INIT)
    ) u_fb_mux (
        .i   (i_q),
        .k   (k_q),
        .acc (acc_q),
        .fb  (fb)
    );

    // 32-bit wrapping sum; overflow is intentionally modulo 2^32.
    always_comb begin
        result = lut_data + fb;
    end

    // Next-state logic for the FSM, bit/bin counters and result registers.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_bin_d   = out_bin_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                i_d = '0;
                k_d = '0;
                // The cycle carrying done is already IDLE; a start there is dropped.
                if (start && !done_q) begin
                    state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                acc_d = result;
                if (i_q == LAST_BIT) begin
                    out_data_d  = result;
                    out_bin_d   = k_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    i_d         = '0;
                    if (k_q == LAST_BIN) begin
                        k_d     = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_ACCUM;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                i_d     = '0;
                k_d     = '0;
            end
        endcase
    end

    // State register with synchronous reset; reset also aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_bin_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_bin_q   <= out_bin_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bit_idx   = i_q;
    assign bin_idx   = k_q;
    assign out_data  = out_data_q;
    assign out_bin   = out_bin_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule
